// File: rtl/ds1_stuff_pkg.sv
// Shared types and widths for the DS1 bit-stuffing controller.
package ds1_stuff_pkg;

    localparam int SPACING_W = 4;
    localparam int CNT_W     = 8;

    // Controller states; ISSUE is always a single-cycle state.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } stuff_state_t;

    // Type of the stuff event waiting for a frame boundary.
    typedef enum logic {
        PEND_ADD = 1'b0,
        PEND_SUB = 1'b1
    } pend_t;

endpackage

// File: rtl/ds1_holdoff_cnt.sv
// Frame-spacing counter: loaded when a command issues, counts frame_sync
// pulses down to zero and flags when the spacing has elapsed.
module ds1_holdoff_cnt
    import ds1_stuff_pkg::*;
(
    input  logic                 ds1ck,
    input  logic                 resetn,
    input  logic                 i_load,
    input  logic [SPACING_W-1:0] i_load_val,
    input  logic                 i_dec,
    output logic                 o_zero
);

    logic [SPACING_W-1:0] r_cnt;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge ds1ck) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ds1_stuff_ctrl.sv
// DS1 positive/negative stuff controller. A level request arms the block,
// the next frame_sync issues a one-cycle add/sub command, then a holdoff of
// spacing_cfg frame boundaries keeps further events apart.
module ds1_stuff_ctrl
    import ds1_stuff_pkg::*;
(
    input  logic                 ds1ck,
    input  logic                 resetn,
    input  logic                 add_req,
    input  logic                 sub_req,
    input  logic                 frame_sync,
    input  logic [SPACING_W-1:0] spacing_cfg,
    output logic                 ds1_add,
    output logic                 ds1_sub,
    output logic                 busy,
    output logic                 conflict,
    output logic                 dropped,
    output logic [CNT_W-1:0]     event_cnt
);

    stuff_state_t        r_state;
    stuff_state_t        w_state_nxt;
    pend_t               r_pend;
    pend_t               w_pend_nxt;
    logic                r_add_d;
    logic                r_sub_d;
    logic                w_add_rise;
    logic                w_sub_rise;
    logic                w_opp_req;
    logic                w_same_rise;
    logic                w_conflict_nxt;
    logic                w_dropped_nxt;
    logic                w_hold_load;
    logic                w_hold_dec;
    logic                w_hold_zero;
    logic                r_ds1_add;
    logic                r_ds1_sub;
    logic                r_busy;
    logic                r_conflict;
    logic                r_dropped;
    logic [CNT_W-1:0]    r_event_cnt;

    assign w_add_rise  = add_req & ~r_add_d;
    assign w_sub_rise  = sub_req & ~r_sub_d;
    assign w_opp_req   = (r_pend == PEND_ADD) ? sub_req : add_req;
    assign w_same_rise = (r_pend == PEND_ADD) ? w_add_rise : w_sub_rise;

    // Spacing is captured only while issuing, so edits during holdoff are inert.
    assign w_hold_load = (r_state == ST_ISSUE);
    assign w_hold_dec  = (r_state == ST_HOLDOFF) && frame_sync;

    ds1_holdoff_cnt u_holdoff (
        .ds1ck      (ds1ck),
        .resetn     (resetn),
        .i_load     (w_hold_load),
        .i_load_val (spacing_cfg),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero)
    );

    // Next-state, pending-type and event-pulse decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_conflict_nxt = 1'b0;
        w_dropped_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (add_req && sub_req) begin
                    w_conflict_nxt = 1'b1;
                end else if (add_req) begin
                    w_pend_nxt  = PEND_ADD;
                    w_state_nxt = ST_ARMED;
                end else if (sub_req) begin
                    w_pend_nxt  = PEND_SUB;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                w_dropped_nxt = w_same_rise;
                if (frame_sync) begin
                    // The frame boundary wins; an opposing request is still flagged.
                    w_state_nxt    = ST_ISSUE;
                    w_conflict_nxt = w_opp_req;
                end else if (w_opp_req) begin
                    w_conflict_nxt = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = (spacing_cfg == '0) ? ST_IDLE : ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                w_dropped_nxt = w_add_rise | w_sub_rise;
                if (w_hold_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pending type and request edge history.
    always_ff @(posedge ds1ck) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_pend  <= PEND_ADD;
            r_add_d <= 1'b0;
            r_sub_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_add_d <= add_req;
            r_sub_d <= sub_req;
        end
    end

    // Registered outputs; command pulses coincide with the ISSUE cycle.
    always_ff @(posedge ds1ck) begin
        if (!resetn) begin
            r_ds1_add   <= 1'b0;
            r_ds1_sub   <= 1'b0;
            r_busy      <= 1'b0;
            r_conflict  <= 1'b0;
            r_dropped   <= 1'b0;
            r_event_cnt <= '0;
        end else begin
            r_ds1_add  <= (w_state_nxt == ST_ISSUE) && (w_pend_nxt == PEND_ADD);
            r_ds1_sub  <= (w_state_nxt == ST_ISSUE) && (w_pend_nxt == PEND_SUB);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_conflict <= w_conflict_nxt;
            r_dropped  <= w_dropped_nxt;
            if (r_state == ST_ISSUE) begin
                r_event_cnt <= r_event_cnt + 1'b1;
            end
        end
    end

    assign ds1_add   = r_ds1_add;
    assign ds1_sub   = r_ds1_sub;
    assign busy      = r_busy;
    assign conflict  = r_conflict;
    assign dropped   = r_dropped;
    assign event_cnt = r_event_cnt;

endmodule

// File: tb/tb_ds1_stuff_ctrl.sv
// Bench for ds1_stuff_ctrl: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural model.
module tb_ds1_stuff_ctrl;

    // ---------------- clock / reset ----------------
    logic       ds1ck = 1'b0;
    logic       resetn = 1'b0;
    logic       add_req = 1'b0;
    logic       sub_req = 1'b0;
    logic       frame_sync = 1'b0;
    logic [3:0] spacing_cfg = 4'd0;
    logic       ds1_add;
    logic       ds1_sub;
    logic       busy;
    logic       conflict;
    logic       dropped;
    logic [7:0] event_cnt;

    always #5 ds1ck = ~ds1ck;

    ds1_stuff_ctrl dut (
        .ds1ck       (ds1ck),
        .resetn      (resetn),
        .add_req     (add_req),
        .sub_req     (sub_req),
        .frame_sync  (frame_sync),
        .spacing_cfg (spacing_cfg),
        .ds1_add     (ds1_add),
        .ds1_sub     (ds1_sub),
        .busy        (busy),
        .conflict    (conflict),
        .dropped     (dropped),
        .event_cnt   (event_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [1:0] exp_q[$];   // expected command sequence: 2'b01 add, 2'b10 sub

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_ISSUE = 2, M_HOLD = 3;
    int m_mode = M_IDLE;
    bit m_pend_sub = 0;
    int m_left = 0;
    int m_cnt = 0;
    bit m_add_d = 0;
    bit m_sub_d = 0;
    bit e_conflict = 0;
    bit e_dropped = 0;

    task automatic model_step();
        bit ar, sr, opp, same_rise;
        ar = add_req && !m_add_d;
        sr = sub_req && !m_sub_d;
        e_conflict = 0;
        e_dropped  = 0;
        if (!resetn) begin
            m_mode = M_IDLE; m_pend_sub = 0; m_left = 0; m_cnt = 0;
            m_add_d = 0; m_sub_d = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (add_req && sub_req) e_conflict = 1;
                    else if (add_req) begin m_pend_sub = 0; m_mode = M_ARMED; end
                    else if (sub_req) begin m_pend_sub = 1; m_mode = M_ARMED; end
                end
                M_ARMED: begin
                    opp       = m_pend_sub ? add_req : sub_req;
                    same_rise = m_pend_sub ? sr : ar;
                    e_dropped = same_rise;
                    if (frame_sync) begin
                        m_mode = M_ISSUE;
                        e_conflict = opp;
                        exp_q.push_back(m_pend_sub ? 2'b10 : 2'b01);
                    end else if (opp) begin
                        e_conflict = 1;
                        m_mode = M_IDLE;
                    end
                end
                M_ISSUE: begin
                    m_cnt  = (m_cnt + 1) % 256;
                    m_left = spacing_cfg;
                    m_mode = (spacing_cfg == 0) ? M_IDLE : M_HOLD;
                end
                default: begin
                    e_dropped = ar || sr;
                    if (m_left == 0) m_mode = M_IDLE;
                    else if (frame_sync) m_left = m_left - 1;
                end
            endcase
            m_add_d = add_req;
            m_sub_d = sub_req;
        end
    endtask

    // ---------------- per-cycle checking and tallies ----------------
    int n_add_p = 0, n_sub_p = 0, n_conf_p = 0, n_drop_p = 0, n_both = 0, n_busy = 0;

    task automatic clr_tally();
        n_add_p = 0; n_sub_p = 0; n_conf_p = 0; n_drop_p = 0; n_both = 0; n_busy = 0;
    endtask

    task automatic compare_all();
        logic [1:0] cmd;
        logic [1:0] exp_cmd;
        chk("ds1_add",   ds1_add,   (m_mode == M_ISSUE) && !m_pend_sub);
        chk("ds1_sub",   ds1_sub,   (m_mode == M_ISSUE) && m_pend_sub);
        chk("busy",      busy,      m_mode != M_IDLE);
        chk("conflict",  conflict,  e_conflict);
        chk("dropped",   dropped,   e_dropped);
        chk("event_cnt", event_cnt, m_cnt);
        chk("add_sub_excl", ds1_add & ds1_sub, 0);
        cmd = {ds1_sub, ds1_add};
        if (cmd != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("cmd_unexpected", cmd, 0);
            end else begin
                exp_cmd = exp_q.pop_front();
                chk("cmd_seq", cmd, exp_cmd);
            end
        end
        n_add_p  += ds1_add;
        n_sub_p  += ds1_sub;
        n_conf_p += conflict;
        n_drop_p += dropped;
        n_both   += (ds1_add & ds1_sub);
        n_busy   += busy;
    endtask

    // Inputs change after the falling edge, are sampled on the rising edge,
    // and outputs are checked on the following falling edge.
    task automatic tick();
        @(posedge ds1ck);
        model_step();
        @(negedge ds1ck);
        compare_all();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit a, input bit s, input bit f);
        add_req = a;
        sub_req = s;
        frame_sync = f;
        tick();
    endtask

    task automatic run_frames(input int n, input int per);
        for (int i = 0; i < n; i++) drive(0, 0, (i % per) == per - 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ra, rs;
        // reset
        resetn = 1'b0;
        repeat (3) drive(0, 0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", event_cnt, 0);
        chk("rst_cmd", {ds1_sub, ds1_add}, 0);
        resetn = 1'b1;

        // S1: single add, spacing 2, frame_sync every 10 cycles
        clr_tally();
        spacing_cfg = 4'd2;
        drive(1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            drive(0, 0, (i % 10) == 9);
            if (i == 8)  chk("s1_no_early_add", ds1_add, 0);
            if (i == 9)  chk("s1_add_latency", ds1_add, 1);
            if (i == 10) chk("s1_add_one_cycle", ds1_add, 0);
            if (i == 19) chk("s1_busy_hold", busy, 1);
        end
        chk("s1_add_count", n_add_p, 1);
        chk("s1_busy_end", busy, 0);
        chk("s1_event_cnt", event_cnt, 1);

        // S2: both requests in IDLE
        clr_tally();
        drive(1, 1, 0);
        chk("s2_conflict", conflict, 1);
        run_frames(5, 100);
        chk("s2_conf_count", n_conf_p, 1);
        chk("s2_no_cmd", n_add_p + n_sub_p, 0);
        chk("s2_busy_never", n_busy, 0);

        // S3: sub armed, then opposing add before any frame boundary
        clr_tally();
        drive(0, 1, 0);
        chk("s3_armed_busy", busy, 1);
        drive(1, 0, 0);
        chk("s3_conflict", conflict, 1);
        chk("s3_cancel_busy", busy, 0);
        run_frames(15, 5);
        chk("s3_conf_count", n_conf_p, 1);
        chk("s3_no_cmd", n_add_p + n_sub_p, 0);
        chk("s3_event_cnt", event_cnt, 1);

        // S4: sub request during holdoff, spacing 3; spacing edited mid-holdoff
        clr_tally();
        spacing_cfg = 4'd3;
        drive(0, 1, 0);
        run_frames(4, 4);
        drive(0, 0, 0);
        chk("s4_in_holdoff", busy, 1);
        drive(0, 1, 0);
        chk("s4_dropped", dropped, 1);
        spacing_cfg = 4'd15;
        run_frames(20, 4);
        chk("s4_sub_count", n_sub_p, 1);
        chk("s4_drop_count", n_drop_p, 1);
        chk("s4_busy_end", busy, 0);
        chk("s4_event_cnt", event_cnt, 2);

        // S5: reset while armed, with frame_sync coincident and just after
        clr_tally();
        drive(0, 1, 0);
        resetn = 1'b0;
        drive(0, 0, 1);
        resetn = 1'b1;
        drive(0, 0, 1);
        run_frames(5, 2);
        chk("s5_no_cmd", n_add_p + n_sub_p, 0);
        chk("s5_event_cnt", event_cnt, 0);
        chk("s5_busy", busy, 0);
        chk("s5_conflict", conflict, 0);
        chk("s5_dropped", dropped, 0);

        // S6: 256 add events with spacing 0, counter wraps
        clr_tally();
        spacing_cfg = 4'd0;
        for (int k = 0; k < 256; k++) begin
            drive(1, 0, 0);
            drive(0, 0, 1);
            drive(0, 0, 0);
            if (k == 254) chk("s6_cnt_255", event_cnt, 255);
        end
        chk("s6_cnt_wrap", event_cnt, 0);
        chk("s6_add_count", n_add_p, 256);
        chk("s6_never_both", n_both, 0);

        // Random traffic: persistent request levels, sparse frame boundaries,
        // occasional spacing edits and resets.
        ra = 0;
        rs = 0;
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) rs = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) spacing_cfg = 4'($urandom_range(0, 5));
            drive(ra, rs, $urandom_range(0, 4) == 0);
        end
        resetn = 1'b1;
        run_frames(100, 3);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ds1_stuff_ctrl.md
DS1_STUFF_CTRL -- requirements
Module: ds1_stuff_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: port ds1ck is the clock and port resetn is the reset.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- ds1ck  in  1  clock; all state updates on posedge
- resetn  in  1  synchronous active-low reset
- add_req  in  1  level request for a positive stuff (add) event
- sub_req  in  1  level request for a negative stuff (sub) event
- frame_sync  in  1  one-cycle pulse marking a DS1 frame boundary
- spacing_cfg  in  4  minimum frame_sync pulses between issued events
- ds1_add  out  1  one-cycle add command pulse
- ds1_sub  out  1  one-cycle sub command pulse
- busy  out  1  high whenever state is not IDLE
- conflict  out  1  one-cycle pulse on simultaneous or opposing requests
- dropped  out  1  one-cycle pulse when a request is ignored during ARMED or HOLDOFF
- event_cnt  out  8  count of issued add plus sub events

Function
REQ-003 The controller SHALL implement four states: IDLE, ARMED, ISSUE and HOLDOFF.
REQ-004 IDLE behaviour SHALL be:
- exactly one of add_req or sub_req sampled high -> latch pend_type (ADD or SUB) and go to ARMED;
- both high -> conflict pulse next cycle, stay IDLE, nothing latched.
REQ-005 ARMED behaviour SHALL be:
- frame_sync high -> go to ISSUE;
- request opposite to pend_type high, without frame_sync -> conflict pulse, cancel, go to IDLE;
- same-type request -> no effect.
REQ-006 frame_sync and an opposite request arriving together in ARMED SHALL resolve in favour of frame_sync: go to ISSUE, and pulse conflict.
REQ-007 ISSUE SHALL last exactly one cycle:
- ds1_add (pend_type ADD) or ds1_sub (SUB) is high for that cycle only;
- event_cnt increments, wrapping 255 -> 0;
- holdoff counter loads spacing_cfg;
- next state is HOLDOFF, or IDLE if spacing_cfg = 0.
REQ-008 Command latency SHALL be one cycle: the pulse appears in the cycle after frame_sync is sampled in ARMED.
REQ-009 ds1_add and ds1_sub SHALL never be high in the same cycle.
REQ-010 HOLDOFF behaviour SHALL be:
- counter decrements on each frame_sync;
- when a decrement reaches 0 -> go to IDLE next cycle;
- spacing_cfg is sampled only in ISSUE; changes during HOLDOFF have no effect.
REQ-011 dropped SHALL pulse for one cycle on the rising edge of add_req or sub_req while in ARMED (opposite type excluded, see REQ-005) or HOLDOFF.
REQ-012 Rising edges SHALL be detected with a one-cycle registered copy of each request input.
REQ-013 A request held high continuously SHALL be re-accepted on return to IDLE, being a level condition.
REQ-014 busy, conflict and dropped SHALL be registered outputs.

Reset
REQ-015 While resetn is low at a ds1ck edge, the block SHALL return to IDLE, including from mid-ARMED, ISSUE or HOLDOFF; no pending command survives.
REQ-016 All outputs SHALL reset to 0: ds1_add, ds1_sub, busy, conflict, dropped, and event_cnt = 8'h00.
REQ-017 The holdoff counter, pend_type and the request edge registers SHALL reset to 0.
REQ-018 A frame_sync coincident with reset SHALL be ignored.

Structure
REQ-019 The state enumeration, the pend_type encoding and the width constants (SPACING_W = 4, CNT_W = 8) SHALL reside in the shared package ds1_stuff_pkg.
REQ-020 The holdoff counter SHALL be a sub-module, ds1_holdoff_cnt, with ports: load, load value, frame_sync decrement enable, and a zero flag.

Verification
REQ-021 The bench SHALL cover at least the following directed scenarios:
- add_req high 1 cycle, spacing_cfg = 2, frame_sync every 10 cycles -> ds1_add exactly 1 cycle, one cycle after the first frame_sync; busy drops after 2 more frame_syncs; event_cnt = 1.
- add_req and sub_req high in the same cycle in IDLE -> conflict one pulse; no ds1_add or ds1_sub; busy stays 0.
- sub_req accepted, then add_req before any frame_sync -> conflict pulse; return to IDLE; no command issued.
- sub_req during HOLDOFF (spacing_cfg = 3) -> dropped one pulse; no extra ds1_sub until IDLE is re-entered.
- resetn low for 1 cycle while in ARMED, followed by frame_sync -> no command; all outputs 0; event_cnt = 0.
- 256 add events with spacing_cfg = 0 -> event_cnt wraps to 0; ds1_add and ds1_sub never high together.
